// File: rtl/btn_debounce_bank.sv
// btn_debounce_bank
// Bank of independent button debouncers. Every channel owns a two-flop
// synchroniser, a tick-qualified debounce counter that must see a new level
// persist before accepting it, one-cycle press/release pulses and a saturating
// hold counter that raises a single long_press pulse per press.
// The falling-edge pulse port is called release_pulse because "release" is a
// reserved word in SystemVerilog.

module btn_debounce_bank #(
  parameter int CHANNELS          = 4,
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic [CHANNELS-1:0] in_signal,
  output logic [CHANNELS-1:0] out_signal,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_press,
  output logic                any_active
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;

  // Two-flop synchroniser for the raw asynchronous inputs; runs every clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_signal;
      sync2 <= sync1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < CHANNELS; g++) begin : g_chan
      logic [DW-1:0] db_cnt;
      logic [HW-1:0] hold_cnt;

      // Debounce: accept a new level only after it persists for
      // DEBOUNCE_CYCLES ticks; any return to the current level restarts it
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          db_cnt           <= '0;
          out_signal[g]    <= 1'b0;
          press[g]         <= 1'b0;
          release_pulse[g] <= 1'b0;
        end else begin
          press[g]         <= 1'b0;
          release_pulse[g] <= 1'b0;
          if (sync2[g] == out_signal[g]) begin
            db_cnt <= '0;
          end else if (ce) begin
            if (db_cnt == DB_LAST) begin
              db_cnt           <= '0;
              out_signal[g]    <= sync2[g];
              press[g]         <= sync2[g];
              release_pulse[g] <= ~sync2[g];
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end
        end
      end

      // Hold timer: counts ticks while pressed, saturates, and pulses
      // long_press once on the step into saturation
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hold_cnt      <= '0;
          long_press[g] <= 1'b0;
        end else begin
          long_press[g] <= 1'b0;
          if (!out_signal[g]) begin
            hold_cnt <= '0;
          end else if (ce && (hold_cnt < HOLD_MAX)) begin
            hold_cnt      <= hold_cnt + 1'b1;
            long_press[g] <= (hold_cnt == HOLD_LAST);
          end
        end
      end
    end
  endgenerate

  assign any_active = |out_signal;

endmodule

// File: tb/tb_btn_debounce_bank.sv
// tb_btn_debounce_bank
// Directed scenarios against a 4-channel bank with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=16. Inputs change 1 ns after a rising edge; outputs are
// sampled 1 ns after each rising edge.

module tb_btn_debounce_bank;

  localparam int CH = 4;

  logic          clk;
  logic          reset;
  logic          ce;
  logic [CH-1:0] in_signal;
  logic [CH-1:0] out_signal;
  logic [CH-1:0] press;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] long_press;
  logic          any_active;

  int checks;
  int errors;

  btn_debounce_bank #(
    .CHANNELS(CH),
    .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ce(ce),
    .in_signal(in_signal),
    .out_signal(out_signal),
    .press(press),
    .release_pulse(release_pulse),
    .long_press(long_press),
    .any_active(any_active)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_signal = '0;
    ce = 1'b1;
    repeat (10) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ce = 1'b1;
    in_signal = '0;
    #3;
    step();
    step();
    checks++;
    if (out_signal !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_out: got %b expected 0000", out_signal);
    end
    checks++;
    if (press !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_press: got %b expected 0000", press);
    end
    checks++;
    if (release_pulse !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_release: got %b expected 0000", release_pulse);
    end
    checks++;
    if (long_press !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_long: got %b expected 0000", long_press);
    end
    checks++;
    if (any_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_any: got %b expected 0", any_active);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single_press();
    logic [CH-1:0] exp_out;
    in_signal = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_out = (e >= 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (out_signal !== exp_out) begin
        errors++;
        $display("[TB] FAIL single_out e=%0d: got %b expected %b", e, out_signal, exp_out);
      end
      checks++;
      if (press !== ((e == 6) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL single_press e=%0d: got %b", e, press);
      end
      checks++;
      if (any_active !== (e >= 6)) begin
        errors++;
        $display("[TB] FAIL single_any e=%0d: got %b", e, any_active);
      end
    end
    in_signal = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (release_pulse !== ((e == 6) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL single_release e=%0d: got %b", e, release_pulse);
      end
      checks++;
      if (long_press !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL single_long e=%0d: got %b expected 0000", e, long_press);
      end
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 20; c++) begin
      in_signal[1] = ((c / 2) % 2 == 0);
      step();
      checks++;
      if (press[1] !== 1'b0 || out_signal[1] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bounce_quiet c=%0d: press=%b out=%b expected 0 0", c, press[1], out_signal[1]);
      end
    end
    in_signal[1] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (press[1] !== (e == 6)) begin
        errors++;
        $display("[TB] FAIL bounce_press e=%0d: got %b expected %b", e, press[1], (e == 6));
      end
    end
    drain();
  endtask

  task automatic test_ce_periodic();
    in_signal = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      ce = (k % 4 == 0);
      step();
      checks++;
      if (press[0] !== (k == 16)) begin
        errors++;
        $display("[TB] FAIL ce_press k=%0d: got %b expected %b", k, press[0], (k == 16));
      end
      checks++;
      if (out_signal[0] !== (k >= 16)) begin
        errors++;
        $display("[TB] FAIL ce_out k=%0d: got %b expected %b", k, out_signal[0], (k >= 16));
      end
    end
    in_signal = 4'b0000;
    for (int k = 1; k <= 20; k++) begin
      ce = (k == 3 || k == 4 || k >= 15);
      step();
      checks++;
      if (release_pulse[0] !== (k == 16)) begin
        errors++;
        $display("[TB] FAIL ce_freeze_release k=%0d: got %b expected %b", k, release_pulse[0], (k == 16));
      end
      checks++;
      if (out_signal[0] !== (k < 16)) begin
        errors++;
        $display("[TB] FAIL ce_freeze_out k=%0d: got %b expected %b", k, out_signal[0], (k < 16));
      end
    end
    drain();
  endtask

  task automatic test_long_press();
    in_signal = 4'b0100;
    for (int e = 1; e <= 40; e++) begin
      step();
      checks++;
      if (press[2] !== (e == 6)) begin
        errors++;
        $display("[TB] FAIL long_press_edge e=%0d: got %b expected %b", e, press[2], (e == 6));
      end
      checks++;
      if (long_press[2] !== (e == 22)) begin
        errors++;
        $display("[TB] FAIL long_pulse e=%0d: got %b expected %b", e, long_press[2], (e == 22));
      end
    end
    in_signal = 4'b0000;
    for (int e = 1; e <= 20; e++) begin
      step();
      checks++;
      if (release_pulse[2] !== (e == 6)) begin
        errors++;
        $display("[TB] FAIL long_release e=%0d: got %b expected %b", e, release_pulse[2], (e == 6));
      end
      checks++;
      if (long_press[2] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL long_second e=%0d: got %b expected 0", e, long_press[2]);
      end
    end
    drain();
  endtask

  task automatic test_simultaneous();
    in_signal = 4'b1001;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (press !== ((e == 6) ? 4'b1001 : 4'b0000)) begin
        errors++;
        $display("[TB] FAIL simul_press e=%0d: got %b", e, press);
      end
      checks++;
      if (any_active !== (e >= 6)) begin
        errors++;
        $display("[TB] FAIL simul_any e=%0d: got %b expected %b", e, any_active, (e >= 6));
      end
    end
    drain();
  endtask

  task automatic test_reset_mid_hold();
    in_signal = 4'b0100;
    for (int e = 1; e <= 16; e++) step();
    reset = 1'b1;
    #1;
    checks++;
    if (out_signal !== 4'b0000 || any_active !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midhold_async: out=%b any=%b expected 0000 0", out_signal, any_active);
    end
    checks++;
    if (press !== 4'b0000 || release_pulse !== 4'b0000 || long_press !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL midhold_pulses: press=%b rel=%b long=%b expected 0", press, release_pulse, long_press);
    end
    step();
    step();
    reset = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      step();
      checks++;
      if (press[2] !== (e == 6)) begin
        errors++;
        $display("[TB] FAIL midhold_press e=%0d: got %b expected %b", e, press[2], (e == 6));
      end
      checks++;
      if (long_press[2] !== (e == 22)) begin
        errors++;
        $display("[TB] FAIL midhold_long e=%0d: got %b expected %b", e, long_press[2], (e == 22));
      end
    end
    drain();
  endtask

  // Scenario sequence
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    ce = 1'b1;
    in_signal = '0;
    test_reset();
    test_single_press();
    test_bounce();
    test_ce_periodic();
    test_long_press();
    test_simultaneous();
    test_reset_mid_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_debounce_bank.md
# btn_debounce_bank

Multi-channel, parametrised button/switch debouncer for the LED controller and any other front panel taking raw mechanical inputs. Each channel has its own two-flop synchroniser, a debounce counter qualified by a shared clock-enable tick, a filtered level output, one-cycle press/release pulses and a long-press detector. It replaces per-button single-channel filters with one bank whose width, debounce depth and long-press threshold are set at instantiation.

## Interface
Parameters:
- CHANNELS, 4: number of independent inputs (≥1).
- DEBOUNCE_CYCLES, 4: consecutive qualifying ticks a new level must persist before it is accepted (≥2).
- LONG_PRESS_CYCLES, 1024: qualifying ticks a channel must remain pressed to raise long_press (≥2).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears every register in the block.
- ce  in  1  tick enable; debounce and hold counters advance only when high.
- in_signal  in  CHANNELS  raw asynchronous inputs, bit i = channel i.
- out_signal  out  CHANNELS  debounced level per channel, registered.
- press  out  CHANNELS  one-cycle pulse when out_signal[i] rises.
- release  out  CHANNELS  one-cycle pulse when out_signal[i] falls.
- long_press  out  CHANNELS  one-cycle pulse when channel i has been held LONG_PRESS_CYCLES ticks.
- any_active  out  1  OR of all out_signal bits (combinational from registers).

## Operation
- Per channel: sync1 <= in_signal[i]; sync2 <= sync1. sync2 is the only value used downstream.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES):
  - sync2 == out_signal[i]: counter <= 0 on every edge, regardless of ce.
  - sync2 != out_signal[i] and ce=1: if counter == DEBOUNCE_CYCLES-1 then out_signal[i] <= sync2, counter <= 0; else counter += 1.
  - sync2 != out_signal[i] and ce=0: counter holds.
- press[i]/release[i] asserted on the same edge out_signal[i] is updated, for exactly one cycle; otherwise 0.
- Hold counter, width $clog2(LONG_PRESS_CYCLES+1), saturating:
  - out_signal[i]=0: cleared to 0.
  - out_signal[i]=1 and ce=1 and counter < LONG_PRESS_CYCLES: += 1.
  - long_press[i] pulses on the edge where counter goes LONG_PRESS_CYCLES-1 -> LONG_PRESS_CYCLES; at saturation no further pulse until a release clears it.
- Channels are fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- ce does not affect synchronisers or counter clearing.

## Timing
- Reset values: out_signal=0, press=0, release=0, long_press=0, any_active=0; synchronisers and all counters 0. Reset mid-debounce or mid-hold discards progress immediately (async).
- Input held high across reset deassertion is reported as a fresh press after full latency.
- Latency with ce=1: input change sampled at edge 1 -> sync2 valid after edge 2 -> out_signal and press/release update at edge DEBOUNCE_CYCLES+2 (6 for default).
- Glitch rejection: any return of sync2 to out_signal level before the counter reaches DEBOUNCE_CYCLES-1 restarts counting from 0; pulses shorter than DEBOUNCE_CYCLES ticks after synchronisation never propagate.
- With ce periodic (one tick every N clocks), debounce time is DEBOUNCE_CYCLES ticks plus up to N-1 cycles of tick alignment, plus 2 sync cycles.
- long_press with ce=1: LONG_PRESS_CYCLES clocks after the press pulse edge.
- press, release, long_press never assert while ce=0.

## Test plan
- Reset, ce=1, defaults: drive in_signal[0] 0->1 held -> out_signal[0] rises and press[0] pulses one cycle exactly 6 edges after first sample; other channels stay 0.
- Bounce: in_signal[1] toggles every 2 cycles for 20 cycles then settles at 1 -> no pulse during toggling; single press[1] 6 edges after final settle.
- ce every 4th cycle, DEBOUNCE_CYCLES=4: step input high -> out_signal rises after 4 ticks (+2 sync, ≤3 alignment cycles); holding ce=0 mid-count freezes progress.
- Long press, LONG_PRESS_CYCLES=16: hold channel 2 for 40 cycles -> exactly one long_press[2] 16 cycles after press[2]; release -> release[2] pulse, no second long_press.
- Simultaneous: channels 0 and 3 change same cycle -> press[0] and press[3] same cycle, any_active rises with them.
- Async reset asserted mid-hold at counter 10 -> all outputs 0 immediately; input still high after deassert -> new press 6 edges later, long_press count restarts from 0.
